// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending scoreboard, sequential clear engine and debug read port.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr_req,
    output logic                   o_clr_busy,
    input  logic [NUM_WR-1:0]      i_wr_en,
    input  logic [NUM_WR*AW-1:0]   i_wr_addr,
    input  logic [NUM_WR*XLEN-1:0] i_wr_data,
    input  logic                   i_iss_en,
    input  logic [AW-1:0]          i_iss_addr,
    input  logic [NUM_RD*AW-1:0]   i_rd_addr,
    output logic [NUM_RD*XLEN-1:0] o_rd_data,
    output logic [NUM_RD-1:0]      o_rd_pending,
    input  logic [AW-1:0]          i_dbg_addr,
    output logic [XLEN-1:0]        o_dbg_data
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [AW-1:0]     r_cnt;
    logic [DEPTH-1:0]  w_wen;
    logic [XLEN-1:0]   w_wdat [DEPTH];
    logic [DEPTH-1:0]  w_iss;

    assign o_clr_busy = r_state == S_CLEAR;
    assign o_dbg_data = r_regs[i_dbg_addr];

    // per-register write decode; later (higher-indexed) ports overwrite earlier ones
    always_comb begin
        w_wen = '0;
        w_iss = '0;
        for (int i = 0; i < DEPTH; i++) w_wdat[i] = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k]) begin
                w_wen[i_wr_addr[k*AW +: AW]]  = 1'b1;
                w_wdat[i_wr_addr[k*AW +: AW]] = i_wr_data[k*XLEN +: XLEN];
            end
        end
        if (i_iss_en) w_iss[i_iss_addr] = 1'b1;
    end

    // register array, scoreboard and clear FSM; register 0 is never written with nonzero data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_pend  <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (r_state == S_CLEAR) begin
            r_regs[r_cnt] <= '0;
            r_cnt         <= r_cnt + AW'(1);
            if (r_cnt == AW'(DEPTH - 1)) r_state <= S_IDLE;
        end else begin
            r_pend[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wen[i]) r_regs[i] <= w_wdat[i];
                r_pend[i] <= w_iss[i] | (r_pend[i] & ~w_wen[i]);
            end
            if (i_clr_req) begin
                r_state <= S_CLEAR;
                r_cnt   <= '0;
                r_pend  <= '0;
            end
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    logic [NUM_WR-1:0] w_byp;

    // write ports eligible to forward: enabled, nonzero target, engine idle
    always_comb begin
        w_byp = '0;
        for (int k = 0; k < NUM_WR; k++)
            w_byp[k] = i_wr_en[k] && (i_wr_addr[k*AW +: AW] != '0) && (r_state == S_IDLE);
    end
`endif

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_rp;
        assign w_ra = i_rd_addr[r*AW +: AW];
        assign o_rd_data[r*XLEN +: XLEN] = w_rd;
        assign o_rd_pending[r] = w_rp;
        // combinational read of stored state, optionally overridden by a same-cycle write
        always_comb begin
            w_rd = (w_ra == '0) ? '0 : r_regs[w_ra];
            w_rp = (w_ra == '0) ? 1'b0 : r_pend[w_ra];
`ifdef REGFILE_MP_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_byp[k] && i_wr_addr[k*AW +: AW] == w_ra) begin
                    w_rd = i_wr_data[k*XLEN +: XLEN];
                    w_rp = i_iss_en && (i_iss_addr == w_ra);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        clr_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pending;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_busy;
    int          m_cnt;

    regfile_mp dut (
        .clk(clk), .rst(rst), .i_clr_req(clr_req), .o_clr_busy(clr_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_pending(rd_pending),
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(int a);
        logic [31:0] v = m_regs[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy && a != 0)
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && int'(wr_addr[k*5 +: 5]) == a) v = wr_data[k*32 +: 32];
`endif
        return v;
    endfunction

    function automatic logic exp_pend(int a);
        logic p = m_pend[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy && a != 0)
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && int'(wr_addr[k*5 +: 5]) == a) p = iss_en && int'(iss_addr) == a;
`endif
        return p;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_regs[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_busy = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wr_addr[k*5 +: 5] != 0) begin
                    m_regs[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
                    m_pend[wr_addr[k*5 +: 5]] = 1'b0;
                end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr_req = 0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0;
    endtask

    task automatic check_all(string tag);
        #1;
        for (int r = 0; r < 2; r++) begin
            int a = int'(rd_addr[r*5 +: 5]);
            chk($sformatf("%s rd%0d data @%0d", tag, r, a), rd_data[r*32 +: 32], exp_rd(a));
            chk($sformatf("%s rd%0d pend @%0d", tag, r, a), {31'b0, rd_pending[r]}, {31'b0, exp_pend(a)});
        end
        chk($sformatf("%s dbg @%0d", tag, dbg_addr), dbg_data, m_regs[dbg_addr]);
        chk($sformatf("%s busy", tag), {31'b0, clr_busy}, {31'b0, m_busy});
    endtask

    task automatic fill();
        for (int a = 1; a < 32; a += 2) begin
            wr_en   = 2'b11;
            wr_addr = {5'(a + 1), 5'(a)};
            wr_data = {$urandom() | 32'h1, $urandom() | 32'h1};
            tick();
        end
        wr_en = '0;
    endtask

    task automatic randomize_inputs(bit allow_clr);
        wr_en    = 2'($urandom());
        wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
        wr_data  = {$urandom(), $urandom()};
        iss_en   = 1'($urandom());
        iss_addr = 5'($urandom_range(0, 7));
        rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
        dbg_addr = 5'($urandom_range(0, 31));
        clr_req  = allow_clr && ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 0; m_cnt = 0;
        idle_inputs();
        rd_addr = '0; dbg_addr = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;

        rd_addr = {5'd5, 5'd0}; dbg_addr = 5'd31;
        check_all("reset");
        chk("reset rd0", rd_data[31:0], 32'h0);
        chk("reset rd1", rd_data[63:32], 32'h0);
        chk("reset dbg31", dbg_data, 32'h0);
        chk("reset busy", {31'b0, clr_busy}, 32'h0);

        wr_en = 2'b11; wr_addr = {5'd0, 5'd7}; wr_data = {32'h1234, 32'hDEADBEEF};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd7}; dbg_addr = 5'd7;
        check_all("write7");
        chk("write7 rd", rd_data[31:0], 32'hDEADBEEF);
        chk("x0 rd", rd_data[63:32], 32'h0);
        chk("write7 dbg", dbg_data, 32'hDEADBEEF);

        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2222, 32'h1111};
        tick();
        idle_inputs();
        rd_addr = {5'd7, 5'd3};
        check_all("collide");
        chk("collide rd3", rd_data[31:0], 32'h2222);

        iss_en = 1; iss_addr = 5'd9;
        tick();
        idle_inputs();
        rd_addr = {5'd9, 5'd0};
        check_all("iss9");
        chk("iss9 pend", {31'b0, rd_pending[1]}, 32'h1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        tick();
        idle_inputs();
        check_all("wb9");
        chk("wb9 pend", {31'b0, rd_pending[1]}, 32'h0);
        iss_en = 1; iss_addr = 5'd9; wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h98, 32'h0};
        tick();
        idle_inputs();
        check_all("iss+wb9");
        chk("iss+wb9 pend", {31'b0, rd_pending[1]}, 32'h1);

        for (int c = 0; c < 150; c++) begin
            randomize_inputs(1'b0);
            check_all($sformatf("rand%0d", c));
            tick();
        end
        idle_inputs();

        fill();
        clr_req = 1;
        tick();
        clr_req = 0;
        n = 0;
        while (clr_busy && n < 100) begin
            randomize_inputs(1'b1);
            check_all($sformatf("clear%0d", n));
            tick();
            n++;
        end
        idle_inputs();
        chk("clear length", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("cleared dbg @%0d", a), dbg_data, 32'h0);
        end

        fill();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int c = 0; c < 9; c++) tick();
        rd_addr = {5'd31, 5'd20}; dbg_addr = 5'd25;
        check_all("midclear");
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rst midclear busy", {31'b0, clr_busy}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("rst midclear dbg @%0d", a), dbg_data, 32'h0);
        end

        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
        tick();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'hCAFE};
        rd_addr = {5'd0, 5'd4}; dbg_addr = 5'd4;
        check_all("bypass same");
`ifdef REGFILE_MP_BYPASS_EN
        chk("bypass same rd4", rd_data[31:0], 32'hCAFE);
`else
        chk("bypass same rd4", rd_data[31:0], 32'h55);
`endif
        chk("bypass dbg4", dbg_data, 32'h55);
        tick();
        idle_inputs();
        check_all("bypass next");
        chk("bypass next rd4", rd_data[31:0], 32'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the next-generation replacement for the single-write, 2-read core register file. Adds configurable width, depth and read/write port counts, a per-register pending scoreboard for hazard detection, a sequential clear engine, and a debug read port that replaces the fixed x31 tap. It sits between decode (reads, issue marking) and writeback (writes).

Parameters:
XLEN, 32, data width of each register in bits
DEPTH, 32, number of registers (power of two, >=2); AW = clog2(DEPTH) is a derived localparam
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
clr_req  in  1  pulse that starts a sequential clear of all registers
clr_busy  out  1  high while a clear is in progress
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  per-port write address; port k occupies bits [k*AW +: AW]
wr_data  in  NUM_WR*XLEN  per-port write data; port k occupies bits [k*XLEN +: XLEN]
iss_en  in  1  mark register iss_addr as pending (producer issued)
iss_addr  in  AW  register to mark pending
rd_addr  in  NUM_RD*AW  per-port read address
rd_data  out  NUM_RD*XLEN  per-port read data
rd_pending  out  NUM_RD  per-port pending flag of the addressed register
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data, combinational

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - all registers become 0 and all pending bits become 0;
  - the FSM goes to IDLE, the clear counter goes to 0, and clr_busy = 0.
  - Reset has priority over every other input, including mid-clear.
- Register 0 is hardwired to zero:
  - writes to address 0 are ignored and iss_en to address 0 is ignored;
  - reads of address 0 return 0 and the pending flag for address 0 is always 0.
- Reads (rd_data, rd_pending, dbg_data) are combinational from the current state, with zero latency.
- Writes take effect at the rising edge. Read-after-write returns the new value on the next cycle.
- Multiple write ports on the same address in the same cycle: the highest-indexed enabled port wins.
- Scoreboard, evaluated at each edge:
  - iss_en sets pending[iss_addr];
  - any enabled write clears pending[wr_addr];
  - if iss_en and a write target the same address in the same cycle, pending ends set (the new producer wins).
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req = 1. On that edge all pending bits clear and the counter loads 0.
  - In CLEAR, each cycle zeroes reg[cnt] and increments cnt. After the cycle in which cnt = DEPTH-1, the FSM returns to IDLE. CLEAR therefore lasts exactly DEPTH cycles.
  - clr_busy = 1 exactly while in CLEAR.
  - In CLEAR, wr_en, iss_en and clr_req are ignored.
  - Reads during CLEAR return the current, partially cleared contents.
- Address inputs are always in range because DEPTH is a power of two.

Optional Feature:
Macro: REGFILE_MP_BYPASS_EN.
- Defined: a read port whose address matches an enabled write port (nonzero address, FSM in IDLE) returns that port's wr_data in the same cycle. If several write ports match, the highest-indexed one is used. rd_pending for that port reads 0 unless iss_en targets the same address in that cycle. dbg_data is never bypassed.
- Not defined: reads always return stored state; the new value is visible one cycle after the write.

Test Plan:
- Reset then read: rst high for 2 cycles, then read addresses 0, 5 and 31 -> rd_data = 0, rd_pending = 0, clr_busy = 0.
- Write and x0 protection: port0 writes 0xDEADBEEF to addr 7 and port1 writes 0x1234 to addr 0 -> next cycle addr 7 reads 0xDEADBEEF and addr 0 reads 0; dbg_addr = 7 gives 0xDEADBEEF.
- Write collision: port0 writes 0x1111 and port1 writes 0x2222 to addr 3 in the same cycle -> addr 3 reads 0x2222.
- Scoreboard: iss_en on addr 9, then on the next cycle rd_pending = 1; a write to addr 9 clears it on the following cycle. Same-cycle iss_en and write to addr 9 -> pending stays 1.
- Clear engine: after filling regs 1..31 with nonzero values, pulse clr_req -> clr_busy high for exactly 32 cycles, writes during that window are ignored, and all regs read 0 afterwards. Asserting rst at cycle 10 of CLEAR -> next cycle clr_busy = 0 and all regs read 0.
- Bypass, with REGFILE_MP_BYPASS_EN defined: write 0xCAFE to addr 4 while rd_addr = 4 -> rd_data = 0xCAFE in the same cycle. Without the macro -> rd_data shows the old value that cycle and 0xCAFE the next.
